// File: rtl/points_frame_sequencer_pkg.sv
// Shared definitions for the points frame sequencer.
//   MAX_POINTS : number of finder point slots captured per frame
//   HEADER     : first byte of every packet
//   IDX_W      : width of the in-packet byte index
//   state_e    : packet FSM states
package points_frame_sequencer_pkg;

  localparam int         MAX_POINTS = 4;
  localparam logic [7:0] HEADER     = 8'hA5;
  localparam int         PKT_MAX    = 4 + 4 * MAX_POINTS;
  localparam int         IDX_W      = $clog2(PKT_MAX);
  localparam int         NUM_W      = $clog2(MAX_POINTS + 1);
  localparam int         PT_W       = $clog2(MAX_POINTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    SUM  = 2'd2
  } state_e;

  // The finder may report more points than there are slots; only the
  // captured slots are ever sent.
  function automatic logic [NUM_W-1:0] clamp_num(input logic [15:0] num);
    if (num > 16'(MAX_POINTS)) return NUM_W'(MAX_POINTS);
    else                       return num[NUM_W-1:0];
  endfunction

endpackage

// File: rtl/pfs_edge_detect.sv
// VS edge detector.
//   clk_i, rst_n_i : clock, async active-low reset
//   vs_i           : vertical sync (already synchronous to clk_i)
//   rise_o, fall_o : single-cycle combinational edge strobes
module pfs_edge_detect (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic vs_i,
  output logic rise_o,
  output logic fall_o
);

  logic vs_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) vs_q <= 1'b0;
    else          vs_q <= vs_i;
  end

  assign rise_o = vs_i & ~vs_q;
  assign fall_o = ~vs_i & vs_q;

endmodule

// File: rtl/points_frame_sequencer.sv
// Frame-level controller for the multi-point finder.
// Clears the finder at start of frame, snapshots its points at end of
// frame and streams the snapshot as a byte packet over valid/ready.
//   CLK, RESET_N          : clock, async active-low reset
//   VGA_VS                : vertical sync, high during active frame
//   i_ENABLE              : capture enable, sampled at VS fall
//   i_POINTS_H/V_0..3     : finder point coordinates
//   i_POINTS_NUM          : finder point count
//   i_TX_READY            : downstream accepts byte
//   o_FINDER_CLR          : one-cycle clear pulse to the finder
//   o_TX_DATA/o_TX_VALID  : packet byte stream
//   o_BUSY                : packet in flight
//   o_FRAME_CNT           : enabled end-of-frame count (wraps)
//   o_DROP_CNT            : frames dropped while busy (saturates)
//
// state | meaning
// IDLE  | no packet in flight, waiting for an accepted VS fall
// SEND  | presenting header / count / n / coordinate byte at idx_q
// SUM   | presenting checksum byte
module points_frame_sequencer
  import points_frame_sequencer_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        VGA_VS,
  input  logic        i_ENABLE,
  input  logic [15:0] i_POINTS_H_0,
  input  logic [15:0] i_POINTS_H_1,
  input  logic [15:0] i_POINTS_H_2,
  input  logic [15:0] i_POINTS_H_3,
  input  logic [15:0] i_POINTS_V_0,
  input  logic [15:0] i_POINTS_V_1,
  input  logic [15:0] i_POINTS_V_2,
  input  logic [15:0] i_POINTS_V_3,
  input  logic [15:0] i_POINTS_NUM,
  input  logic        i_TX_READY,
  output logic        o_FINDER_CLR,
  output logic [7:0]  o_TX_DATA,
  output logic        o_TX_VALID,
  output logic        o_BUSY,
  output logic [7:0]  o_FRAME_CNT,
  output logic [7:0]  o_DROP_CNT
);

  logic vs_rise, vs_fall;

  pfs_edge_detect u_edge (
    .clk_i   (CLK),
    .rst_n_i (RESET_N),
    .vs_i    (VGA_VS),
    .rise_o  (vs_rise),
    .fall_o  (vs_fall)
  );

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [15:0]       snap_h_q [MAX_POINTS];
  logic [15:0]       snap_v_q [MAX_POINTS];
  logic [NUM_W-1:0]  snap_n_q;
  logic [7:0]        snap_cnt_q;
  logic [7:0]        frame_cnt_q;
  logic [7:0]        drop_cnt_q;
  logic              clr_q;

  logic [15:0]       in_h [MAX_POINTS];
  logic [15:0]       in_v [MAX_POINTS];

  assign in_h[0] = i_POINTS_H_0;
  assign in_h[1] = i_POINTS_H_1;
  assign in_h[2] = i_POINTS_H_2;
  assign in_h[3] = i_POINTS_H_3;
  assign in_v[0] = i_POINTS_V_0;
  assign in_v[1] = i_POINTS_V_1;
  assign in_v[2] = i_POINTS_V_2;
  assign in_v[3] = i_POINTS_V_3;

  logic             xfer;
  logic             fall_en;
  logic             accept;
  logic [IDX_W-1:0] last_idx;

  assign xfer    = o_TX_VALID & i_TX_READY;
  assign fall_en = vs_fall & i_ENABLE;
  // A new frame may start in the same cycle the checksum leaves, so the
  // next packet follows with no idle gap.
  assign accept  = fall_en & ((state_q == IDLE) | ((state_q == SUM) & xfer));
  // Index of the last byte sent from SEND: n byte at 2, then 4 per point.
  assign last_idx = IDX_W'({snap_n_q, 2'b00}) + IDX_W'(2);

  // Byte mux: coordinate bytes start at index 3, four per point.
  logic [PT_W+1:0] coord_off;
  logic [PT_W-1:0] pt;
  logic [15:0]     coord_h, coord_v;
  logic [7:0]      tx_byte;

  assign coord_off = (PT_W + 2)'(idx_q - IDX_W'(3));
  assign pt        = coord_off[PT_W+1:2];
  assign coord_h   = snap_h_q[pt];
  assign coord_v   = snap_v_q[pt];

  always_comb begin
    tx_byte = 8'h00;
    if (idx_q == IDX_W'(0))      tx_byte = HEADER;
    else if (idx_q == IDX_W'(1)) tx_byte = snap_cnt_q;
    else if (idx_q == IDX_W'(2)) tx_byte = 8'(snap_n_q);
    else begin
      case (coord_off[1:0])
        2'd0:    tx_byte = coord_h[15:8];
        2'd1:    tx_byte = coord_h[7:0];
        2'd2:    tx_byte = coord_v[15:8];
        default: tx_byte = coord_v[7:0];
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          idx_d   = '0;
          sum_d   = 8'h00;
        end
      end
      SEND: begin
        if (xfer) begin
          if (idx_q != IDX_W'(0)) sum_d = sum_q + tx_byte;
          if (idx_q == last_idx) state_d = SUM;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      SUM: begin
        if (xfer) begin
          if (accept) begin
            state_d = SEND;
            idx_d   = '0;
            sum_d   = 8'h00;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sum_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < MAX_POINTS; k++) begin
        snap_h_q[k] <= 16'h0000;
        snap_v_q[k] <= 16'h0000;
      end
      snap_n_q   <= '0;
      snap_cnt_q <= 8'h00;
    end else if (accept) begin
      for (int k = 0; k < MAX_POINTS; k++) begin
        snap_h_q[k] <= in_h[k];
        snap_v_q[k] <= in_v[k];
      end
      snap_n_q   <= clamp_num(i_POINTS_NUM);
      snap_cnt_q <= frame_cnt_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_cnt_q <= 8'h00;
      drop_cnt_q  <= 8'h00;
      clr_q       <= 1'b0;
    end else begin
      clr_q <= vs_rise;
      if (fall_en) frame_cnt_q <= frame_cnt_q + 8'd1;
      if (fall_en && !accept && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign o_TX_VALID   = (state_q != IDLE);
  assign o_BUSY       = (state_q != IDLE);
  assign o_TX_DATA    = (state_q == SEND) ? tx_byte :
                        (state_q == SUM)  ? sum_q   : 8'h00;
  assign o_FINDER_CLR = clr_q;
  assign o_FRAME_CNT  = frame_cnt_q;
  assign o_DROP_CNT   = drop_cnt_q;

endmodule
